param_extend_pipe: RTL
======================

Name: param_extend_pipe

Overview:
Parametrised, pipelined width extender for the ALU datapath. Widens an IN_W-bit operand to OUT_W bits using one of four runtime-selectable fill modes: zero, sign, ones and upper-placement. Uses a valid/ready handshake and a 2-entry output buffer (main + skid), so it sits between the immediate/operand source and the ALU input with no combinational in-to-out path. Supersedes the fixed 32-bit zero-only extender.

Parameters:
IN_W, 8, input operand width; 1 <= IN_W <= OUT_W.
OUT_W, 32, output width.
CNT_W, 16, width of the completed-transfer counter.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  in_data/in_mode are valid this cycle.
in_ready  output  1  block can accept this cycle; driven from a register.
in_data  input  IN_W  operand to extend.
in_mode  input  2  00 zero-ext, 01 sign-ext, 10 ones-fill, 11 upper-place.
out_valid  output  1  out_data is valid.
out_ready  input  1  consumer accepts this cycle.
out_data  output  OUT_W  extended result.
xfer_count  output  CNT_W  number of completed output transfers; wraps.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, in_ready=1, skid empty, xfer_count=0.
- A reset mid-transfer discards both buffered entries. Inputs presented in the reset cycle are not accepted.
- Input handshake: accept when in_valid && in_ready. Output handshake: transfer when out_valid && out_ready.
- Extension is computed at accept time, and the extended value is what gets stored.
- Mode 00: out = {(OUT_W-IN_W) zeros, in_data}.
- Mode 01: out = {(OUT_W-IN_W) copies of in_data[IN_W-1], in_data}.
- Mode 10: out = {(OUT_W-IN_W) ones, in_data}.
- Mode 11: out = {in_data, (OUT_W-IN_W) zeros}.
- When IN_W == OUT_W, all modes pass in_data unchanged.
- Latency: an operand accepted at edge N is visible on out_data with out_valid=1 after edge N. Minimum latency is 1 cycle.
- Throughput: 1 per cycle while out_ready=1.
- Buffer update, evaluated each edge:
  - main empty or draining, skid empty, accept: main <= new.
  - main draining, skid full: main <= skid; skid empties. No accept is possible because in_ready=0.
  - main full, not draining, accept: skid <= new; in_ready=0 from next cycle.
  - main draining, no accept, skid empty: out_valid=0 next cycle.
- in_ready = !skid_full, registered. It deasserts the cycle after the skid fills and reasserts the cycle after the skid drains into main.
- Ordering: strictly FIFO. Nothing is dropped or duplicated.
- out_data holds its value while out_valid=1 && out_ready=0. It retains its last value when out_valid=0.
- xfer_count increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.
- in_mode values are all defined, so there are no illegal codes.
- Elaboration must fail (generate-time error) if IN_W > OUT_W or IN_W < 1.

Test Plan:
- Modes (IN_W=8, OUT_W=32, out_ready=1), 0xA5 presented in each mode -> one cycle after each accept, out_data is:
  - mode 00: 0x000000A5.
  - mode 01: 0xFFFFFFA5.
  - mode 10: 0xFFFFFFA5.
  - mode 11: 0xA5000000.
  - Additionally, 0x25 in mode 01 -> 0x00000025, and 0x25 in mode 10 -> 0xFFFFFF25.
- Backpressure: out_ready=0, in_valid=1 with 0x01, 0x02, 0x03 on consecutive cycles -> 0x01 and 0x02 accepted and in_ready=0 from cycle 3. Then raise out_ready -> outputs are 0x01, 0x02, 0x03 in order, with 0x03 accepted after in_ready reasserts. xfer_count=3.
- Streaming: 100 back-to-back inputs with out_ready=1 -> in_ready stays 1, one output per cycle, xfer_count=100.
- Random valid/ready toggling for 1000 cycles -> scoreboard matches exactly; out_data is stable whenever out_valid && !out_ready.
- Reset mid-operation: skid full, assert reset for 1 cycle -> next cycle out_valid=0, in_ready=1, xfer_count=0. Old data never appears.
- Wrap and edge widths: CNT_W=4, 17 transfers -> xfer_count reads 0 after the 16th and 1 after the 17th. IN_W=OUT_W=16, in_data 0x8000 in mode 01 -> 0x8000.

Source files
------------

// File: rtl/param_extend_pipe.sv
// param_extend_pipe
//
// Pipelined width extender for the ALU operand path. It widens an IN_W-bit
// operand to OUT_W bits with one of four fill modes, selected per operand.
// The extension is computed when the operand is accepted, and the widened
// value is stored. A main register and a skid register decouple the input
// and output handshakes, so there is no combinational path from input to
// output.
//
// Parameters:
//   IN_W   operand width, 1 <= IN_W <= OUT_W
//   OUT_W  result width
//   CNT_W  width of the completed-transfer counter (wraps)
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   in_valid    in_data/in_mode are valid this cycle
//   in_ready    block can accept this cycle (registered)
//   in_data     operand to extend
//   in_mode     00 zero-ext, 01 sign-ext, 10 ones-fill, 11 upper-place
//   out_valid   out_data is valid
//   out_ready   consumer accepts this cycle
//   out_data    extended result; holds while stalled and after draining
//   xfer_count  number of completed output transfers
module param_extend_pipe #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] xfer_count
);

    localparam int PAD_W = OUT_W - IN_W;

    // An operand wider than the result, or a zero-width operand, cannot be
    // extended meaningfully. Stop elaboration rather than build bad hardware.
    generate
        if (IN_W < 1 || IN_W > OUT_W) begin : g_bad_width
            $error("param_extend_pipe: IN_W must satisfy 1 <= IN_W <= OUT_W");
        end
    endgenerate

    // The mask covers the upper PAD_W bits. It is all-zero when IN_W == OUT_W,
    // so every mode collapses to a pass-through with no special-casing.
    localparam logic [OUT_W-1:0] FILL_MASK = ~OUT_W'({IN_W{1'b1}});

    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] ext_value;

    logic             main_valid_q, main_valid_d;
    logic [OUT_W-1:0] main_data_q,  main_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [OUT_W-1:0] skid_data_q,  skid_data_d;
    logic             in_ready_q,   in_ready_d;
    logic [CNT_W-1:0] count_q,      count_d;

    logic accept;
    logic drain;

    assign accept = in_valid && in_ready_q;
    assign drain  = main_valid_q && out_ready;

    // Form the widened operand from the current input and fill mode.
    // Upper placement shifts the zero-extended operand into the top bits.
    always_comb begin
        zext      = OUT_W'(in_data);
        ext_value = zext;
        unique case (in_mode)
            2'b00: ext_value = zext;
            2'b01: ext_value = in_data[IN_W-1] ? (zext | FILL_MASK) : zext;
            2'b10: ext_value = zext | FILL_MASK;
            2'b11: ext_value = zext << PAD_W;
            default: ext_value = zext;
        endcase
    end

    // Two-entry buffer update. Main always holds the oldest entry, and the
    // skid only fills when main is stalled. This keeps the entries strictly
    // in FIFO order. in_ready is derived from the next skid state, so it
    // drops the cycle after the skid fills and rises the cycle after the skid
    // moves into main.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        count_d      = count_q;

        if (drain) begin
            count_d = count_q + CNT_W'(1);
            if (skid_valid_q) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_data_d  = ext_value;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (!main_valid_q) begin
            if (accept) begin
                main_valid_d = 1'b1;
                main_data_d  = ext_value;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = ext_value;
        end

        in_ready_d = !skid_valid_d;
    end

    // State registers with synchronous reset. A reset empties both entries
    // and ignores any operand offered in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
            count_q      <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
            count_q      <= count_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = main_valid_q;
    assign out_data   = main_data_q;
    assign xfer_count = count_q;

endmodule
